// File: rtl/fixed_point_iterative_pkg.sv
// Shared definitions for the iterative fixed-point divider.
// state_t : control FSM encoding (IDLE / CALC / DONE), 2 bits wide.
package fixed_point_iterative_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fixed_point_iterative_divider_datapath.sv
// Datapath of the iterative fixed-point divider: operand magnitudes,
// restoring shift-subtract loop (one quotient bit per step), sign fix-up
// and divide-by-zero result selection.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   load_i     : capture a_i / b_i and initialise the loop
//   step_i     : perform one shift-subtract iteration
//   last_i     : final iteration; register the fixed-up quotient into c_o
//   a_i, b_i   : dividend / divisor (n bits, d fractional bits)
//   c_o        : quotient, held until the next final iteration
module fixed_point_iterative_divider_datapath #(
  parameter int n    = 32,
  parameter int d    = 16,
  parameter int sign = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         step_i,
  input  logic         last_i,
  input  logic [n-1:0] a_i,
  input  logic [n-1:0] b_i,
  output logic [n-1:0] c_o
);

  localparam int QW = n + d;

  // Dividend shifts out of the top while quotient bits shift in at the bottom.
  logic [QW-1:0] dvd_q;
  // Remainder is always below the divisor (<= 2^(n-1)), so n bits suffice.
  logic [n-1:0]  rem_q;
  logic [n:0]    div_q;
  logic          neg_q;
  logic          a_neg_q;
  logic          bz_q;
  logic [n-1:0]  c_q;

  logic [n:0]    rem_sh;
  logic          qbit;

  // n+1 bits so the most-negative operand's magnitude 2^(n-1) is representable.
  function automatic logic [n:0] mag(input logic [n-1:0] x);
    logic [n:0] ext;
    ext = {(sign != 0) & x[n-1], x};
    if ((sign != 0) && x[n-1]) mag = -ext;
    else                       mag = ext;
  endfunction

  function automatic logic [n-1:0] fixup(input logic [n-1:0] q,
                                         input logic neg,
                                         input logic bz,
                                         input logic an);
    if (bz) begin
      // Divide-by-zero saturates toward the dividend's sign.
      if (sign == 0)  fixup = '1;
      else if (an)    fixup = {1'b1, {(n-1){1'b0}}};
      else            fixup = {1'b0, {(n-1){1'b1}}};
    end else if (neg) begin
      fixup = -q;
    end else begin
      fixup = q;
    end
  endfunction

  assign rem_sh = {rem_q, dvd_q[QW-1]};
  assign qbit   = (rem_sh >= div_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      neg_q   <= 1'b0;
      a_neg_q <= 1'b0;
      bz_q    <= 1'b0;
      c_q     <= '0;
    end else if (load_i) begin
      // Magnitude never exceeds 2^(n-1), so dropping its top bit is lossless.
      dvd_q   <= QW'({mag(a_i), {d{1'b0}}});
      div_q   <= mag(b_i);
      rem_q   <= '0;
      neg_q   <= (sign != 0) && (a_i[n-1] ^ b_i[n-1]);
      a_neg_q <= (sign != 0) && a_i[n-1];
      bz_q    <= (b_i == '0);
    end else if (step_i) begin
      rem_q <= n'(qbit ? rem_sh - div_q : rem_sh);
      dvd_q <= {dvd_q[QW-2:0], qbit};
      if (last_i) c_q <= fixup({dvd_q[n-2:0], qbit}, neg_q, bz_q, a_neg_q);
    end
  end

  assign c_o = c_q;

endmodule

// File: rtl/fixed_point_iterative_divider.sv
// Iterative fixed-point divider: c = trunc((a * 2^d) / b), low n bits kept.
// A control FSM (IDLE -> CALC for n+d cycles -> DONE) sequences the
// shift-subtract datapath; valid/ready handshakes on both sides.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   recv_rdy, recv_val : operand handshake (accept in IDLE only)
//   a, b               : dividend, divisor (n bits, d fractional bits)
//   send_rdy, send_val : result handshake (valid in DONE only)
//   c                  : quotient, stable from DONE until next accept
module fixed_point_iterative_divider
  import fixed_point_iterative_pkg::*;
#(
  parameter int n    = 32,
  parameter int d    = 16,
  parameter int sign = 1
) (
  input  logic         clk,
  input  logic         reset,
  output logic         recv_rdy,
  input  logic         recv_val,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         send_rdy,
  output logic         send_val,
  output logic [n-1:0] c
);

  localparam int            CW       = $clog2(n + d);
  localparam logic [CW-1:0] LAST_CNT = CW'(n + d - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load, step, last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    recv_rdy = 1'b0;
    send_val = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    last     = 1'b0;
    unique case (state_q)
      IDLE: begin
        recv_rdy = 1'b1;
        if (recv_val) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt_q == LAST_CNT) begin
          last    = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        send_val = 1'b1;
        if (send_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  fixed_point_iterative_divider_datapath #(
    .n    (n),
    .d    (d),
    .sign (sign)
  ) u_datapath (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .step_i (step),
    .last_i (last),
    .a_i    (a),
    .b_i    (b),
    .c_o    (c)
  );

endmodule

// File: tb/tb_fixed_point_iterative_divider.sv
module tb_fixed_point_iterative_divider;

  logic        clk;
  logic        reset;
  // signed instance
  logic        recv_rdy, recv_val, send_rdy, send_val;
  logic [31:0] a, b, c;
  // unsigned instance
  logic        u_recv_rdy, u_recv_val, u_send_rdy, u_send_val;
  logic [31:0] u_a, u_b, u_c;

  logic [31:0] exp_q[$];
  logic [31:0] u_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  fixed_point_iterative_divider #(.n(32), .d(16), .sign(1)) u_dut (
    .clk(clk), .reset(reset), .recv_rdy(recv_rdy), .recv_val(recv_val),
    .a(a), .b(b), .send_rdy(send_rdy), .send_val(send_val), .c(c)
  );

  fixed_point_iterative_divider #(.n(32), .d(16), .sign(0)) u_dut_u (
    .clk(clk), .reset(reset), .recv_rdy(u_recv_rdy), .recv_val(u_recv_val),
    .a(u_a), .b(u_b), .send_rdy(u_send_rdy), .send_val(u_send_val), .c(u_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, act, expv);
    end
  endtask

  // Independent reference: 64-bit integer division on magnitudes.
  function automatic logic [31:0] model(input logic [31:0] av, input logic [31:0] bv, input bit sgn);
    logic [63:0] ma, mb, q;
    bit na, nb;
    na = sgn && av[31];
    nb = sgn && bv[31];
    if (bv == 32'h0) begin
      if (!sgn) return 32'hFFFF_FFFF;
      return av[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
    ma = na ? (64'h1_0000_0000 - {32'h0, av}) : {32'h0, av};
    mb = nb ? (64'h1_0000_0000 - {32'h0, bv}) : {32'h0, bv};
    q  = (ma << 16) / mb;
    if (na ^ nb) q = -q;
    return q[31:0];
  endfunction

  // Scoreboard monitors: a result is consumed when send_val && send_rdy.
  always @(negedge clk) begin
    if (!reset && send_val && send_rdy) begin
      if (exp_q.size() == 0) check_val("spurious_out", {31'b0, send_val}, 32'h0);
      else check_val("c_signed", c, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!reset && u_send_val && u_send_rdy) begin
      if (u_q.size() == 0) check_val("spurious_out_u", {31'b0, u_send_val}, 32'h0);
      else check_val("c_unsigned", u_c, u_q.pop_front());
    end
  end

  // Issue one operation and wait for send_val. Latency counts the accept
  // edge as cycle 1, so n+d CALC cycles give send_val on cycle n+d+1 = 49.
  // With poke set, recv_val stays high with junk operands while busy.
  task automatic run_op(input bit uns, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ev, input bit poke);
    int lat;
    lat = 0;
    while (!(uns ? u_recv_rdy : recv_rdy) && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    if (lat >= 200) check_val("rdy_timeout", 32'(lat), 32'd0);
    if (uns) begin
      u_a = av; u_b = bv; u_recv_val = 1'b1; u_q.push_back(ev);
    end else begin
      a = av; b = bv; recv_val = 1'b1; exp_q.push_back(ev);
    end
    @(posedge clk); #1;
    u_recv_val = 1'b0;
    recv_val   = poke;
    check_val("busy_after_accept", {31'b0, uns ? u_recv_rdy : recv_rdy}, 32'h0);
    lat = 1;
    while (!(uns ? u_send_val : send_val) && lat < 200) begin
      if (poke) begin a = $urandom; b = $urandom; end
      @(posedge clk); #1; lat++;
    end
    recv_val = 1'b0;
    check_val("latency", 32'(lat), 32'd49);
  endtask

  initial begin
    logic [31:0] av, bv;
    reset = 1'b1;
    recv_val = 1'b0; a = '0; b = '0; send_rdy = 1'b1;
    u_recv_val = 1'b0; u_a = '0; u_b = '0; u_send_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_recv_rdy", {31'b0, recv_rdy}, 32'h1);
    check_val("rst_send_val", {31'b0, send_val}, 32'h0);
    check_val("rst_c", c, 32'h0);
    reset = 1'b0;

    // Directed cases; the first is driven right after reset release.
    run_op(0, 32'h0006_0000, 32'h0002_0000, 32'h0003_0000, 0);
    run_op(0, 32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1);
    run_op(0, 32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 0);
    run_op(0, 32'hFFFA_0000, 32'h0002_0000, 32'hFFFD_0000, 0);
    run_op(0, 32'h0005_0000, 32'h0000_0000, 32'h7FFF_FFFF, 0);
    run_op(0, 32'hFFFB_0000, 32'h0000_0000, 32'h8000_0000, 0);
    run_op(0, 32'h0000_0000, 32'h1234_0000, 32'h0000_0000, 0);
    run_op(1, 32'hFFFA_0000, 32'h0002_0000, 32'h7FFD_0000, 0);
    run_op(1, 32'h0005_0000, 32'h0000_0000, 32'hFFFF_FFFF, 0);

    // Consumer stall: result and flags must hold while send_rdy is low.
    send_rdy = 1'b0;
    run_op(0, 32'h0006_0000, 32'h0002_0000, 32'h0003_0000, 0);
    for (int i = 0; i < 10; i++) begin
      recv_val = 1'b1; a = $urandom; b = $urandom;
      @(posedge clk); #1;
      check_val("stall_send_val", {31'b0, send_val}, 32'h1);
      check_val("stall_c", c, 32'h0003_0000);
      check_val("stall_recv_rdy", {31'b0, recv_rdy}, 32'h0);
    end
    recv_val = 1'b0;
    send_rdy = 1'b1;
    @(posedge clk); #1;
    check_val("idle_recv_rdy", {31'b0, recv_rdy}, 32'h1);
    check_val("idle_send_val", {31'b0, send_val}, 32'h0);
    run_op(0, 32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 0);

    // Abort in CALC: the in-flight result must never appear.
    @(posedge clk); #1;
    a = 32'h0009_0000; b = 32'h0002_0000; recv_val = 1'b1;
    @(posedge clk); #1;
    recv_val = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_val("abort_recv_rdy", {31'b0, recv_rdy}, 32'h1);
    check_val("abort_send_val", {31'b0, send_val}, 32'h0);
    check_val("abort_c", c, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_op(0, 32'h0006_0000, 32'h0002_0000, 32'h0003_0000, 0);

    // Randomised operands against the reference model, with edge values.
    for (int i = 0; i < 8; i++) begin
      av = $urandom;
      bv = $urandom >> $urandom_range(0, 20);
      if (i == 0) begin av = 32'h8000_0000; bv = 32'h0001_0000; end
      if (i == 1) bv = 32'h8000_0000;
      run_op(0, av, bv, model(av, bv, 1'b1), 0);
    end
    for (int i = 0; i < 3; i++) begin
      av = $urandom;
      bv = $urandom >> $urandom_range(4, 20);
      run_op(1, av, bv, model(av, bv, 1'b0), 0);
    end

    repeat (3) @(posedge clk);
    #1;
    check_val("sb_drain", 32'(exp_q.size() + u_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fixed_point_iterative_divider.md
FIXED_POINT_ITERATIVE_DIVIDER -- requirements
Module: fixed_point_iterative_divider

Interface
REQ-001 SHALL have parameter n, default 32, total bit width of operands and result.
REQ-002 SHALL have parameter d, default 16, number of fractional bits (0 < d < n).
REQ-003 SHALL have parameter sign, default 1, 1 = two's-complement signed, 0 = unsigned.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port recv_rdy, output, 1, block can accept operands.
REQ-007 SHALL have port recv_val, input, 1, operands a/b valid.
REQ-008 SHALL have port a, input, n, dividend, fixed point with d fractional bits.
REQ-009 SHALL have port b, input, n, divisor, same format.
REQ-010 SHALL have port send_rdy, input, 1, consumer can take the result.
REQ-011 SHALL have port send_val, output, 1, result c valid.
REQ-012 SHALL have port c, output, n, quotient, same format.

Function
REQ-013 SHALL compute c = trunc((a * 2^d) / b) on integer representations, rounding toward zero, keeping the low n bits (overflow wraps).
REQ-014 SHALL implement sign=1 by dividing magnitudes and negating the quotient iff a[n-1] XOR b[n-1]; magnitude of the most-negative input is 2^(n-1) (n+1-bit internal magnitude).
REQ-015 SHALL use a restoring shift-subtract algorithm producing one quotient bit per cycle over an (n+d)-bit left-shifted dividend.
REQ-016 SHALL have states IDLE, CALC, DONE.
REQ-017 SHALL transition IDLE->CALC when recv_val=1, capturing a and b in that cycle; otherwise stay in IDLE.
REQ-018 SHALL stay in CALC for exactly n+d cycles (counter 0..n+d-1, width $clog2(n+d)), then go to DONE.
REQ-019 SHALL go DONE->IDLE when send_rdy=1; otherwise hold DONE with c and send_val stable.
REQ-020 SHALL drive recv_rdy=1 only in IDLE and send_val=1 only in DONE; the two are never high together.
REQ-021 SHALL take n+d+1 cycles from the accept edge to send_val=1.
REQ-022 SHALL ignore a, b and recv_val outside IDLE.
REQ-023 SHALL, on b=0, produce all-ones for sign=0; for sign=1, 0x7F..F if a >= 0 and 0x80..0 if a < 0; timing is unchanged (still n+d CALC cycles).
REQ-024 SHALL produce c=0 when a=0 and b != 0.
REQ-025 SHALL keep c stable from DONE entry until the next operand acceptance.
REQ-026 SHALL accept new operands in the cycle after a DONE->IDLE transition if recv_val=1 (no extra dead cycles).

Reset
REQ-027 SHALL, while reset=1 and regardless of clk, force state=IDLE, counter=0, the quotient/remainder/divisor registers=0, c=0, send_val=0, and recv_rdy=1.
REQ-028 SHALL abort any in-flight CALC or DONE when reset asserts mid-operation, and never emit the aborted result.
REQ-029 SHALL accept operands on the first rising edge after reset deasserts if recv_val=1.

Structure
REQ-030 SHALL take the state typedef (IDLE/CALC/DONE, 2 bits) from shared package fixed_point_iterative_pkg.
REQ-031 SHALL split into a control FSM in the top module and sub-module fixed_point_iterative_divider_datapath (magnitude, shift-subtract, sign fix-up, divide-by-zero select).
REQ-032 SHALL use asynchronous-reset registers for all datapath registers, not synchronous-reset library registers.

Verification (n=32, d=16, sign=1 unless stated)
REQ-033 SHALL test a=0x00060000, b=0x00020000 -> c=0x00030000, with send_val high exactly 49 cycles after the accept edge.
REQ-034 SHALL test a=0x00010000, b=0x00030000 -> c=0x00005555; and a=0xFFFF0000, b=0x00030000 -> c=0xFFFFAAAB (truncation toward zero).
REQ-035 SHALL test a=0xFFFA0000, b=0x00020000 -> c=0xFFFD0000; and sign=0 with a=0xFFFA0000, b=0x00020000 -> c=0x7FFD0000.
REQ-036 SHALL test b=0 with a=0x00050000 -> 0x7FFFFFFF and a=0xFFFB0000 -> 0x80000000, both after 48 CALC cycles.
REQ-037 SHALL test send_rdy held low 10 cycles in DONE -> c and send_val stable, recv_rdy=0; then send_rdy=1 -> IDLE next cycle, and a back-to-back transaction is accepted the following cycle.
REQ-038 SHALL test reset asserted at CALC cycle 20 -> recv_rdy=1 and send_val=0 immediately; a fresh 6.0/2.0 then yields 0x00030000.
